// File: rtl/disaggregator.sv
// Purpose : replays one packed word of up to FETCH_WIDTH lanes as one lane per cycle, lane 0 first.
// Latency : word dequeued in cycle N presents lane 0 with receiver_enq in cycle N+1.
// Backpressure: receiver_full_n low freezes idx/buf/receiver_data; no sender_deq while stalled mid-word.
//
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   sender_data/_empty_n/_deq   - first-word-fall-through source of packed words
//   receiver_data/_full_n/_enq  - narrow per-lane consumer
//   change_fetch_width, input_fetch_width - one-cycle request for a new lane count
//   receiver_last               - final lane marker, present only when DISAGGREGATOR_LAST_EN is defined
module disaggregator #(
    parameter int DATA_WIDTH  = 8,
    parameter int FETCH_WIDTH = 6,
    parameter int CNT_WIDTH   = $clog2(FETCH_WIDTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
    input  logic                              sender_empty_n,
    output logic                              sender_deq,
    output logic [DATA_WIDTH-1:0]             receiver_data,
    input  logic                              receiver_full_n,
    output logic                              receiver_enq,
    input  logic                              change_fetch_width,
    input  logic [CNT_WIDTH-1:0]              input_fetch_width
`ifdef DISAGGREGATOR_LAST_EN
   ,output logic                              receiver_last
`endif
);

    typedef enum logic {EMPTY, ACTIVE} state_t;

    state_t                            state, state_nxt;
    logic [FETCH_WIDTH*DATA_WIDTH-1:0] word_buf, word_buf_nxt;
    logic [CNT_WIDTH-1:0]              idx, idx_nxt;
    logic [CNT_WIDTH-1:0]              fw, fw_nxt;
    logic [CNT_WIDTH-1:0]              pend_fw, pend_fw_nxt;
    logic                              pend_vld, pend_vld_nxt;

    logic                              at_last;
    logic                              boundary;
    logic                              req_ok;
    logic [CNT_WIDTH-1:0]              req_fw;
    logic                              eff_vld;
    logic [CNT_WIDTH-1:0]              eff_fw;

    assign at_last      = (idx == fw - CNT_WIDTH'(1));
    assign receiver_enq = (state == ACTIVE) && receiver_full_n && !rst;
    // A word may be taken when nothing is buffered or the last lane leaves this cycle.
    assign boundary     = (state == EMPTY) || (receiver_enq && at_last);
    assign sender_deq   = sender_empty_n && boundary && !rst;

`ifdef DISAGGREGATOR_LAST_EN
    assign receiver_last = (state == ACTIVE) && at_last;
`endif

    // Lane select; idx never reaches FETCH_WIDTH.
    always_comb begin
        receiver_data = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (idx == CNT_WIDTH'(i)) begin
                receiver_data = word_buf[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A zero request is ignored; oversize requests saturate.
    assign req_ok  = change_fetch_width && (input_fetch_width != '0);
    assign req_fw  = (input_fetch_width > CNT_WIDTH'(FETCH_WIDTH)) ? CNT_WIDTH'(FETCH_WIDTH)
                                                                   : input_fetch_width;
    // A request in the current cycle overrides any older pending one, and may apply at once.
    assign eff_vld = req_ok || pend_vld;
    assign eff_fw  = req_ok ? req_fw : pend_fw;

    always_comb begin
        state_nxt    = state;
        word_buf_nxt = word_buf;
        idx_nxt      = idx;
        fw_nxt       = fw;
        pend_fw_nxt  = eff_fw;
        pend_vld_nxt = eff_vld;

        // Width only switches between words, so a word loaded now already uses the new width.
        if (boundary && eff_vld) begin
            fw_nxt       = eff_fw;
            pend_vld_nxt = 1'b0;
        end

        case (state)
            EMPTY: begin
                if (sender_deq) begin
                    word_buf_nxt = sender_data;
                    idx_nxt      = '0;
                    state_nxt    = ACTIVE;
                end
            end
            ACTIVE: begin
                if (receiver_enq) begin
                    if (!at_last) begin
                        idx_nxt = idx + CNT_WIDTH'(1);
                    end else if (sender_deq) begin
                        word_buf_nxt = sender_data;
                        idx_nxt      = '0;
                    end else begin
                        idx_nxt   = '0;
                        state_nxt = EMPTY;
                    end
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            word_buf <= '0;
            idx      <= '0;
            fw       <= CNT_WIDTH'(FETCH_WIDTH);
            pend_fw  <= CNT_WIDTH'(FETCH_WIDTH);
            pend_vld <= 1'b0;
        end else begin
            state    <= state_nxt;
            word_buf <= word_buf_nxt;
            idx      <= idx_nxt;
            fw       <= fw_nxt;
            pend_fw  <= pend_fw_nxt;
            pend_vld <= pend_vld_nxt;
        end
    end

endmodule

// File: tb/tb_disaggregator.sv
// Bench for disaggregator: scoreboard of expected lanes filled when words are
// offered, table of fetch-width requests, and hand-written stall/reset sequences.
module tb_disaggregator;
    localparam int DW = 8;
    localparam int FW = 6;
    localparam int CW = $clog2(FW + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [FW*DW-1:0]  sender_data = '0;
    logic              sender_empty_n = 1'b0;
    logic              sender_deq;
    logic [DW-1:0]     receiver_data;
    logic              receiver_full_n = 1'b1;
    logic              receiver_enq;
    logic              change_fetch_width = 1'b0;
    logic [CW-1:0]     input_fetch_width = '0;
    logic              s_last = 1'b0;
`ifdef DISAGGREGATOR_LAST_EN
    logic              receiver_last;
`endif

    disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
        .clk(clk), .rst(rst),
        .sender_data(sender_data), .sender_empty_n(sender_empty_n), .sender_deq(sender_deq),
        .receiver_data(receiver_data), .receiver_full_n(receiver_full_n), .receiver_enq(receiver_enq),
        .change_fetch_width(change_fetch_width), .input_fetch_width(input_fetch_width)
`ifdef DISAGGREGATOR_LAST_EN
       ,.receiver_last(receiver_last)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [DW-1:0] data; logic last; } exp_t;
    typedef struct { int req; int exp_fw; } vec_t;

    exp_t              exp_q[$];
    logic [FW*DW-1:0]  snd_q[$];
    int                deq_cyc[$];
    int                enq_cyc[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                cyc     = 0;
    int                word_no = 0;
    int                cur_fw  = FW;
    logic              rand_mode = 1'b0;
    logic              gate = 1'b1;
    logic              s_enq, s_deq;
    logic [DW-1:0]     s_data;

    task automatic check(input string nm, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
    endtask

    task automatic refresh();
        sender_empty_n = gate && (snd_q.size() > 0);
        sender_data    = (snd_q.size() > 0) ? snd_q[0] : '0;
    endtask

    // Offer a word whose lane i = 6k+i; expect its first nl lanes on the output.
    task automatic push_word(input int nl);
        logic [FW*DW-1:0] w;
        for (int i = 0; i < FW; i++) w[i*DW +: DW] = DW'((FW * word_no + i) & 255);
        snd_q.push_back(w);
        for (int i = 0; i < nl; i++) exp_q.push_back({w[i*DW +: DW], (i == nl - 1)});
        word_no++;
        refresh();
    endtask

    // One clock: sample and score at the falling edge, then drive just after the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        s_enq  = receiver_enq;
        s_deq  = sender_deq;
        s_data = receiver_data;
`ifdef DISAGGREGATOR_LAST_EN
        s_last = receiver_last;
`endif
        if (s_deq) deq_cyc.push_back(cyc);
        if (s_enq) begin
            enq_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("extra_enq", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("lane_data", int'(s_data), int'(e.data));
`ifdef DISAGGREGATOR_LAST_EN
                check("lane_last", int'(s_last), int'(e.last));
`endif
            end
        end
        @(posedge clk);
        #1;
        if (s_deq) void'(snd_q.pop_front());
        if (rand_mode) begin
            gate            = ($urandom_range(0, 3) != 0);
            receiver_full_n = ($urandom_range(0, 2) != 0);
        end
        refresh();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || snd_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) timeout("drain");
        repeat (3) step();
    endtask

    task automatic wait_enq(input int base, input int cnt);
        int n = 0;
        while (enq_cyc.size() - base < cnt && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) timeout("wait_enq");
    endtask

    task automatic req_width(input int v);
        change_fetch_width = 1'b1;
        input_fetch_width  = CW'(v);
        step();
        change_fetch_width = 1'b0;
        input_fetch_width  = '0;
    endtask

    initial begin
        vec_t vecs[5];
        int   be, bd;

        vecs[0] = '{0, 4};
        vecs[1] = '{7, 6};
        vecs[2] = '{1, 1};
        vecs[3] = '{3, 3};
        vecs[4] = '{6, 6};

        // Reset state.
        repeat (3) step();
        check("rst_enq", int'(s_enq), 0);
        check("rst_deq", int'(s_deq), 0);
        check("rst_data", int'(s_data), 0);
`ifdef DISAGGREGATOR_LAST_EN
        check("rst_last", int'(s_last), 0);
`endif
        rst = 1'b0;
        step();

        // Sustained stream, default width: no gaps, one deq per 6 lanes, lane 0 one cycle after deq.
        be = enq_cyc.size(); bd = deq_cyc.size();
        repeat (4) push_word(FW);
        drain(200);
        check("tp_enq_count", enq_cyc.size() - be, 24);
        check("tp_deq_count", deq_cyc.size() - bd, 4);
        check("tp_latency", enq_cyc[be] - deq_cyc[bd], 1);
        check("tp_no_gap", enq_cyc[be + 23] - enq_cyc[be], 23);
        check("tp_deq_spacing", deq_cyc[bd + 1] - deq_cyc[bd], 6);

        // Width change to 4 requested mid-packet at idx 2.
        be = enq_cyc.size(); bd = deq_cyc.size();
        push_word(FW);
        push_word(4);
        wait_enq(be, 2);
        req_width(4);
        cur_fw = 4;
        drain(200);
        check("mid_enq_count", enq_cyc.size() - be, 10);
        check("mid_deq_count", deq_cyc.size() - bd, 2);

        // Idle width requests: zero ignored, oversize clamps, width 1 deqs on every enq.
        for (int v = 0; v < 5; v++) begin
            req_width(vecs[v].req);
            cur_fw = vecs[v].exp_fw;
            be = enq_cyc.size(); bd = deq_cyc.size();
            push_word(cur_fw);
            push_word(cur_fw);
            drain(200);
            check($sformatf("tbl%0d_enq_count", v), enq_cyc.size() - be, 2 * cur_fw);
            check($sformatf("tbl%0d_deq_count", v), deq_cyc.size() - bd, 2);
        end

        // Consumer stall right after load: data held, nothing moves.
        receiver_full_n = 1'b0;
        push_word(FW);
        push_word(FW);
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_enq", int'(s_enq), 0);
            check("stall_deq", int'(s_deq), 0);
            check("stall_data", int'(s_data), (FW * (word_no - 2)) & 255);
        end
        receiver_full_n = 1'b1;
        drain(200);

        // Random producer/consumer gaps: scoreboard order must match the unstalled stream.
        rand_mode = 1'b1;
        be = enq_cyc.size();
        repeat (8) push_word(FW);
        drain(3000);
        rand_mode = 1'b0;
        gate = 1'b1;
        receiver_full_n = 1'b1;
        refresh();
        check("rand_enq_count", enq_cyc.size() - be, 48);

        // Reset at idx 3 with a pending width request: lanes dropped, width back to 6.
        be = enq_cyc.size();
        push_word(FW);
        push_word(FW);
        wait_enq(be, 1);
        req_width(2);
        wait_enq(be, 3);
        rst = 1'b1;
        exp_q.delete();
        foreach (snd_q[j]) begin
            for (int i = 0; i < FW; i++) exp_q.push_back({snd_q[j][i*DW +: DW], (i == FW - 1)});
        end
        step();
        check("mrst_enq", int'(s_enq), 0);
        check("mrst_deq", int'(s_deq), 0);
        step();
        check("mrst_data", int'(s_data), 0);
        rst = 1'b0;
        be = enq_cyc.size(); bd = deq_cyc.size();
        drain(200);
        check("mrst_enq_count", enq_cyc.size() - be, 6);
        check("mrst_deq_count", deq_cyc.size() - bd, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
